tdm_demux5_rx: RTL and testbench
================================

Name: tdm_demux5_rx

Overview:
- 1-to-N time-division demultiplexer: the receive end of the 5:1 select-mux datapath.
- Accepts a serial stream of W-bit samples, one per slot, with a frame-sync marker on slot 0.
- Steers each sample into the channel register addressed by an internal slot counter (the counterpart of the mux select).
- Presents all N channels in parallel with a one-cycle frame-valid strobe.

Parameters:
- N, 5, channels (slots) per frame; legal range 2..8.
- W, 1, sample width in bits.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- din  in  W  serial sample.
- din_valid  in  1  din holds a sample this cycle.
- sync  in  1  marks the current sample as slot 0. Ignored when din_valid=0.
- dout  out  N*W  parallel frame; channel k occupies bits [k*W +: W].
- frame_valid  out  1  one-cycle strobe: dout updated with a complete frame.
- slot  out  3  slot index the next accepted sample will occupy.
- locked  out  1  high while in RUN.
- sync_err  out  1  one-cycle strobe on a framing violation.

Behaviour:
- Reset: when rst=1 at a rising edge, all outputs and internal shadow registers go to 0 and the state goes to IDLE. This applies at any point, including mid-frame; any partial frame is discarded.
- Only cycles with din_valid=1 are sample cycles. All other cycles hold state, and frame_valid and sync_err are 0.
- States are IDLE and RUN. locked = (state==RUN).
- IDLE:
  - Sample with sync=0: dropped, no flags.
  - Sample with sync=1: din goes to shadow[0], slot becomes 1, state goes to RUN.
- RUN, sample with sync=0 and slot=k where 1<=k<=N-1:
  - din goes to shadow[k].
  - If k<N-1: slot becomes k+1.
  - If k==N-1 (frame complete): at the same edge, dout loads {din, shadow[N-2..0]} and frame_valid=1 for the following cycle only; slot becomes 0; state stays RUN.
- RUN, slot=0, sample with sync=1: normal frame start. din goes to shadow[0], slot becomes 1.
- RUN, slot=0, sample with sync=0 (lost sync):
  - sync_err=1 for one cycle.
  - Sample dropped, state goes to IDLE, slot stays 0.
- RUN, slot!=0, sample with sync=1 (early sync):
  - sync_err=1 for one cycle.
  - Partial frame discarded; shadow contents may remain but are never emitted.
  - din goes to shadow[0], slot becomes 1, state stays RUN.
- Output holding: dout changes only on frame completion and holds its value between frames and through IDLE. frame_valid and sync_err never assert in the same cycle.
- Latency: the last sample of a frame appears on dout, with frame_valid, one clock after the edge that samples it.
- Throughput: back-to-back frames are supported at one sample per cycle, with no gap between frames.
- slot width: fixed at 3 bits; the counter wraps from N-1 to 0.

Optional Feature:
- Macro: TDM_DEMUX_ERRCNT_EN.
- Defined:
  - Adds output port err_cnt (out, 8 bits).
  - err_cnt is an 8-bit saturating count of sync_err strobes: it increments on every sync_err strobe and stops at 255.
  - Cleared to 0 only by rst.
- Undefined: port and logic are absent; all other behaviour is identical.

Test Plan:
1. Basic frame: reset, then 5 consecutive valid samples 1,0,0,0,1 with sync on the first. Required: next cycle dout=5'b10001, frame_valid=1 for exactly one cycle; slot steps 1,2,3,4,0; locked=1 from the cycle after the first sample.
2. Back-to-back frames: stream 1,0,0,0,1 then 0,1,1,0,0 continuously, sync on each slot 0, no gaps. Required: two frame_valid pulses 5 cycles apart, dout=10001 then 00110; sync_err never asserts.
3. Gapped input: same frame as scenario 1 with din_valid=0 inserted between each sample. Required: dout=10001 as in scenario 1; frame_valid asserts only after the 5th valid sample; state is unaffected by idle cycles.
4. Early sync: 3 samples 1,1,1 (first with sync), then sync with the frame 0,0,0,0,1. Required: sync_err pulses once at the 4th sample; the next frame_valid shows dout=10000 with no trace of the 1s; err_cnt=1 when the macro is defined.
5. Lost sync and IDLE drop:
   - Stimulus: after one full frame, a sample with sync=0 at slot 0, then 3 samples without sync, then a valid synced frame.
   - Required: one sync_err pulse; locked falls and IDLE samples produce no flags; dout holds the old frame until the synced frame completes.
6. Reset mid-frame: rst=1 for one cycle after slot 2 of a frame. Required: the next cycle shows dout=0, slot=0, locked=0, err_cnt=0; subsequent samples without sync are ignored.

Source files
------------

// File: rtl/tdm_demux5_rx.sv
// -----------------------------------------------------------------------------
// tdm_demux5_rx
//   Receive end of an N:1 time-division select-mux link. Samples arrive one
//   per slot with a frame-sync marker on slot 0; each is steered into the
//   shadow register picked by an internal slot counter. When the last slot
//   arrives, the whole frame is presented in parallel on dout together with
//   a one-cycle frame_valid strobe.
//
// Parameters
//   N  channels (slots) per frame, 2..8
//   W  sample width in bits
//
// Ports
//   clk          rising-edge clock
//   rst          synchronous active-high reset
//   din          serial sample
//   din_valid    din holds a sample this cycle
//   sync         current sample is slot 0 (ignored when din_valid=0)
//   dout         parallel frame, channel k at [k*W +: W]
//   frame_valid  one-cycle strobe: dout was loaded with a complete frame
//   slot         slot the next accepted sample will occupy
//   locked       high while framing is established (RUN)
//   sync_err     one-cycle strobe on a framing violation
//   err_cnt      (TDM_DEMUX_ERRCNT_EN only) saturating count of sync_err
//
// Optional feature macro: TDM_DEMUX_ERRCNT_EN
// -----------------------------------------------------------------------------
module tdm_demux5_rx #(
  parameter int N = 5,
  parameter int W = 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [W-1:0]   din,
  input  logic           din_valid,
  input  logic           sync,
  output logic [N*W-1:0] dout,
  output logic           frame_valid,
  output logic [2:0]     slot,
  output logic           locked,
  output logic           sync_err
`ifdef TDM_DEMUX_ERRCNT_EN
  ,
  output logic [7:0]     err_cnt
`endif
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  localparam logic [2:0] LAST_SLOT = 3'(N - 1);

  state_t               state;
  // Slots 0..N-2 are buffered; the last slot goes straight from din to dout.
  logic [(N-1)*W-1:0]   shadow;

  assign locked = (state == RUN);

  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the shadow bank is cleared on reset too, so no stale sample from
      // before reset can ever be observed; it is small enough to be flops.
      state       <= IDLE;
      slot        <= '0;
      shadow      <= '0;
      dout        <= '0;
      frame_valid <= 1'b0;
      sync_err    <= 1'b0;
`ifdef TDM_DEMUX_ERRCNT_EN
      err_cnt     <= '0;
`endif
    end else begin
      // NOTE: strobes default low every cycle and are only raised below;
      // all state here uses non-blocking assignments so every branch sees
      // the pre-edge values of slot/state/shadow.
      frame_valid <= 1'b0;
      sync_err    <= 1'b0;

      if (din_valid) begin
        unique case (state)
          IDLE: begin
            // Unsynced samples are dropped silently while hunting for sync.
            if (sync) begin
              shadow[0 +: W] <= din;
              slot           <= 3'd1;
              state          <= RUN;
            end
          end

          RUN: begin
            if (sync) begin
              // Sync anywhere but slot 0 restarts the frame; the partial
              // frame stays in shadow but will be overwritten before use.
              if (slot != 3'd0) begin
                sync_err <= 1'b1;
`ifdef TDM_DEMUX_ERRCNT_EN
                if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
`endif
              end
              shadow[0 +: W] <= din;
              slot           <= 3'd1;
            end else if (slot == 3'd0) begin
              // Missing sync where one was due: drop lock and the sample.
              sync_err <= 1'b1;
              state    <= IDLE;
`ifdef TDM_DEMUX_ERRCNT_EN
              if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
`endif
            end else if (slot == LAST_SLOT) begin
              dout        <= {din, shadow};
              frame_valid <= 1'b1;
              slot        <= 3'd0;
            end else begin
              // Constant-index loop keeps the write decode within the
              // shadow bank regardless of the 3-bit slot width.
              for (int k = 1; k < N - 1; k++) begin
                if (slot == 3'(k)) shadow[k*W +: W] <= din;
              end
              slot <= slot + 3'd1;
            end
          end

          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_tdm_demux5_rx.sv
module tb_tdm_demux5_rx;

  localparam int N = 5;
  localparam int W = 1;

  logic           clk = 1'b0;
  logic           rst;
  logic [W-1:0]   din;
  logic           din_valid;
  logic           sync;
  logic [N*W-1:0] dout;
  logic           frame_valid;
  logic [2:0]     slot;
  logic           locked;
  logic           sync_err;
`ifdef TDM_DEMUX_ERRCNT_EN
  logic [7:0]     err_cnt;
`endif

  tdm_demux5_rx #(.N(N), .W(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .din         (din),
    .din_valid   (din_valid),
    .sync        (sync),
    .dout        (dout),
    .frame_valid (frame_valid),
    .slot        (slot),
    .locked      (locked),
    .sync_err    (sync_err)
`ifdef TDM_DEMUX_ERRCNT_EN
    ,
    .err_cnt     (err_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Scoreboard entry: kind 2'b10 = frame strobe, 2'b01 = sync_err strobe.
  typedef struct {
    logic [1:0]     kind;
    logic [N*W-1:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic push_frame(input logic [N*W-1:0] d);
    exp_t e;
    e.kind = 2'b10;
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic push_err();
    exp_t e;
    e.kind = 2'b01;
    e.data = '0;
    exp_q.push_back(e);
  endtask

  // One valid sample; returns #1 after the sampling edge.
  task automatic send(input logic d, input logic s);
    @(negedge clk);
    din       = d;
    sync      = s;
    din_valid = 1'b1;
    @(posedge clk);
    #1;
    din_valid = 1'b0;
    sync      = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Send a full synced frame given as per-slot samples, expecting it on dout.
  task automatic send_frame(input logic [N-1:0] smp, input string tag);
    for (int k = 0; k < N; k++) begin
      if (k == N - 1) push_frame(smp);
      send(smp[k], k == 0);
      check({tag, " slot"}, 32'(slot), 32'((k + 1) % N));
      check({tag, " locked"}, 32'(locked), 32'd1);
    end
  endtask

  task automatic drain(input string tag);
    idle(2);
    check({tag, " pending"}, 32'(exp_q.size()), 32'd0);
  endtask

  // Monitor: every output strobe must match the oldest expected event.
  always @(negedge clk) begin
    if (rst !== 1'b1 && (frame_valid || sync_err)) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected strobe: fv=%0b err=%0b dout=%0h at %0t",
                 frame_valid, sync_err, dout, $time);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("strobe kind", 32'({frame_valid, sync_err}), 32'(e.kind));
        if (e.kind == 2'b10) check("frame dout", 32'(dout), 32'(e.data));
      end
    end
  end

  initial begin
    rst = 1'b1; din = '0; din_valid = 1'b0; sync = 1'b0;
    idle(2);
    check("reset dout", 32'(dout), 32'd0);
    check("reset slot", 32'(slot), 32'd0);
    check("reset locked", 32'(locked), 32'd0);
    check("reset strobes", 32'({frame_valid, sync_err}), 32'd0);
`ifdef TDM_DEMUX_ERRCNT_EN
    check("reset err_cnt", 32'(err_cnt), 32'd0);
`endif
    @(negedge clk); rst = 1'b0;

    // 1. Basic frame: samples 1,0,0,0,1 -> dout 5'b10001.
    send_frame(5'b10001, "s1");
    check("s1 fv latency", 32'(frame_valid), 32'd1);
    idle(1);
    check("s1 fv one cycle", 32'(frame_valid), 32'd0);
    drain("s1");

    // 2. Back-to-back frames, no gap.
    send_frame(5'b10001, "s2a");
    send_frame(5'b00110, "s2b");
    drain("s2");
    check("s2 dout hold", 32'(dout), 32'h06);

    // 3. Gapped input.
    for (int k = 0; k < N; k++) begin
      if (k == N - 1) push_frame(5'b10001);
      send(k == 0 || k == N - 1, k == 0);
      check("s3 slot", 32'(slot), 32'((k + 1) % N));
      if (k != N - 1) begin
        idle(1);
        check("s3 gap slot", 32'(slot), 32'(k + 1));
        check("s3 gap no fv", 32'(frame_valid), 32'd0);
      end
    end
    drain("s3");

    // 4. Early sync: 1,1,1 then a new synced frame 0,0,0,0,1.
    send(1'b1, 1'b1);
    send(1'b1, 1'b0);
    send(1'b1, 1'b0);
    push_err();
    send_frame(5'b10000, "s4");
    drain("s4");
`ifdef TDM_DEMUX_ERRCNT_EN
    check("s4 err_cnt", 32'(err_cnt), 32'd1);
`endif

    // 5. Lost sync, IDLE drops, then resync.
    send_frame(5'b01011, "s5a");
    push_err();
    send(1'b1, 1'b0);
    check("s5 lost locked", 32'(locked), 32'd0);
    check("s5 lost slot", 32'(slot), 32'd0);
    for (int k = 0; k < 3; k++) begin
      send(1'b1, 1'b0);
      check("s5 idle locked", 32'(locked), 32'd0);
      check("s5 idle slot", 32'(slot), 32'd0);
    end
    idle(1);
    check("s5 dout hold", 32'(dout), 32'h0B);
    send_frame(5'b11100, "s5b");
    drain("s5");
`ifdef TDM_DEMUX_ERRCNT_EN
    check("s5 err_cnt", 32'(err_cnt), 32'd2);
`endif

    // 6. Reset mid-frame after slot 2.
    send(1'b1, 1'b1);
    send(1'b1, 1'b0);
    send(1'b1, 1'b0);
    check("s6 pre slot", 32'(slot), 32'd3);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    check("s6 dout", 32'(dout), 32'd0);
    check("s6 slot", 32'(slot), 32'd0);
    check("s6 locked", 32'(locked), 32'd0);
`ifdef TDM_DEMUX_ERRCNT_EN
    check("s6 err_cnt", 32'(err_cnt), 32'd0);
`endif
    @(negedge clk); rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      send(1'b1, 1'b0);
      check("s6 ignored slot", 32'(slot), 32'd0);
      check("s6 ignored locked", 32'(locked), 32'd0);
    end
    drain("s6");
    check("s6 dout stays 0", 32'(dout), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
